// File: rtl/apb_protocol_monitor.sv
`default_nettype none
// ============================================================================
// Module   : apb_protocol_monitor
// Passive APB3 checker: sticky violation flags, error and transfer counters.
// Optional : APB_MON_TIMEOUT_EN enables the ACCESS_WAIT timeout check (bit 8).
// Revision : 1.0
// ============================================================================
module apb_protocol_monitor #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [DATA_WIDTH-1:0] pwdata,
  input  logic                  pready,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  clr_err,
  output logic [1:0]            apb_state,
  output logic [8:0]            err_vec,
  output logic                  err_pulse,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic [CNT_WIDTH-1:0]  xfer_count
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_LAST  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  pwrite_q, pwrite_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pready_q, pready_d;
  logic                  valid_q, valid_d;
  logic [8:0]            err_vec_q, err_vec_d;
  logic                  err_pulse_q, err_pulse_d;
  logic [CNT_WIDTH-1:0]  err_count_q, err_count_d;
  logic [CNT_WIDTH-1:0]  xfer_count_q, xfer_count_d;

  logic [8:0] fail;
  logic       any_fail;
  logic       cur_access;
  logic       check_en;
  logic       tmo_fire;

  // Read data is observed but never checked.
  logic unused_prdata;
  assign unused_prdata = ^prdata;

  always_comb begin
    apb_state = ST_IDLE;
    if (psel) begin
      if (!penable)     apb_state = ST_SETUP;
      else if (!pready) apb_state = ST_WAIT;
      else              apb_state = ST_LAST;
    end
  end

  assign cur_access = psel & penable;
  assign check_en   = valid_q & ~preset;

`ifdef APB_MON_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // Counter saturates at the limit so the error fires once per wait run.
  always_comb begin
    tmo_cnt_d = '0;
    tmo_fire  = 1'b0;
    if (apb_state == ST_WAIT) begin
      if (tmo_cnt_q != TMO_W'(TIMEOUT_CYCLES)) tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
      else                                     tmo_cnt_d = tmo_cnt_q;
      tmo_fire = check_en && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) tmo_cnt_q <= '0;
    else        tmo_cnt_q <= tmo_cnt_d;
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign tmo_fire = 1'b0;
`endif

  always_comb begin
    fail = '0;
    if (check_en) begin
      fail[0] = (state_q == ST_IDLE)  &  cur_access;
      fail[1] = (state_q == ST_SETUP) & ~cur_access;
      fail[2] = (state_q == ST_WAIT)  & ~cur_access;
      fail[3] = (state_q == ST_LAST)  &  cur_access;
      fail[4] = ((paddr != paddr_q) | (pwrite != pwrite_q)) & cur_access;
      fail[5] = (pwdata != pwdata_q) & pwrite & cur_access;
      fail[6] = penable_q & ~penable & psel & ~(penable_q & pready_q);
      fail[7] = psel_q & ~psel & ~(penable_q & pready_q);
    end
    fail[8] = tmo_fire;
  end

  assign any_fail = |fail;

  always_comb begin
    state_d   = apb_state;
    paddr_d   = paddr;
    pwdata_d  = pwdata;
    pwrite_d  = pwrite;
    psel_d    = psel;
    penable_d = penable;
    pready_d  = pready;
    valid_d   = 1'b1;

    err_pulse_d = any_fail;
    err_vec_d   = clr_err ? fail : (err_vec_q | fail);

    // A failure in the clearing cycle still counts as one.
    err_count_d = err_count_q;
    if (clr_err)                          err_count_d = any_fail ? CNT_WIDTH'(1) : '0;
    else if (any_fail && err_count_q != '1) err_count_d = err_count_q + CNT_WIDTH'(1);

    xfer_count_d = xfer_count_q + CNT_WIDTH'(apb_state == ST_LAST);
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q      <= ST_IDLE;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      pwrite_q     <= 1'b0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pready_q     <= 1'b0;
      valid_q      <= 1'b0;
      err_vec_q    <= '0;
      err_pulse_q  <= 1'b0;
      err_count_q  <= '0;
      xfer_count_q <= '0;
    end else begin
      state_q      <= state_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      pwrite_q     <= pwrite_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pready_q     <= pready_d;
      valid_q      <= valid_d;
      err_vec_q    <= err_vec_d;
      err_pulse_q  <= err_pulse_d;
      err_count_q  <= err_count_d;
      xfer_count_q <= xfer_count_d;
    end
  end

  assign err_vec    = err_vec_q;
  assign err_pulse  = err_pulse_q;
  assign err_count  = err_count_q;
  assign xfer_count = xfer_count_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_protocol_monitor.sv
`default_nettype none
// Testbench for apb_protocol_monitor: expected monitor outputs are queued per driven
// sample and compared once the registered outputs reflect that sample.
module tb_apb_protocol_monitor;

  localparam int TMO = 4;
`ifdef APB_MON_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif
  localparam int K_IDLE  = 0;
  localparam int K_SETUP = 1;
  localparam int K_WAIT  = 2;
  localparam int K_LAST  = 3;

  logic        pclk = 1'b0;
  logic        preset = 1'b1;
  logic [31:0] paddr = '0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] pwdata = '0;
  logic        pready = 1'b0;
  logic [31:0] prdata = 32'hDEAD_BEEF;
  logic        clr_err = 1'b0;
  logic [1:0]  apb_state;
  logic [8:0]  err_vec;
  logic        err_pulse;
  logic [15:0] err_count;
  logic [15:0] xfer_count;

  always #5 pclk = ~pclk;

  apb_protocol_monitor #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .CNT_WIDTH(16), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .pclk(pclk), .preset(preset), .paddr(paddr), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pready(pready), .prdata(prdata),
    .clr_err(clr_err), .apb_state(apb_state), .err_vec(err_vec), .err_pulse(err_pulse),
    .err_count(err_count), .xfer_count(xfer_count)
  );

  typedef struct {
    int          kind;
    logic [31:0] a;
    logic        wr;
    logic [31:0] d;
    logic        clr;
    logic        chk;
    logic [8:0]  vec;
    logic        pulse;
    logic [15:0] cnt;
    logic [15:0] xfer;
  } step_t;

  typedef struct {
    logic [8:0]  vec;
    logic        pulse;
    logic [15:0] cnt;
    logic [15:0] xfer;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  function automatic step_t st(input int kind, input logic [31:0] a, input logic wr,
                               input logic [31:0] d, input logic clr, input logic chk,
                               input logic [8:0] vec, input logic pulse,
                               input logic [15:0] cnt, input logic [15:0] xfer);
    step_t s;
    s.kind = kind; s.a = a; s.wr = wr; s.d = d; s.clr = clr; s.chk = chk;
    s.vec = vec; s.pulse = pulse; s.cnt = cnt; s.xfer = xfer;
    return s;
  endfunction

  task automatic bus(input step_t s);
    psel    = (s.kind != K_IDLE);
    penable = (s.kind == K_WAIT) || (s.kind == K_LAST);
    pready  = (s.kind == K_LAST);
    paddr   = s.a;
    pwrite  = s.wr;
    pwdata  = s.d;
    clr_err = s.clr;
    @(posedge pclk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    preset = 1'b1;
    exp_q.push_back('{9'h0, 1'b0, 16'd0, 16'd0});
    repeat (3) bus(st(K_IDLE, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 9'h0, 1'b0, 16'd0, 16'd0));
    e = exp_q.pop_front();
    checks++;
    if ({err_vec, err_pulse, err_count, xfer_count} !== {e.vec, e.pulse, e.cnt, e.xfer})
      $display("FAIL reset_hold: got vec=%03h pulse=%b cnt=%0d xfer=%0d, want vec=%03h pulse=%b cnt=%0d xfer=%0d",
               err_vec, err_pulse, err_count, xfer_count, e.vec, e.pulse, e.cnt, e.xfer);
    else passes++;
    checks++;
    if (apb_state !== 2'd0) $display("FAIL reset_state: got %0d, want 0", apb_state);
    else passes++;
    preset = 1'b0;
    exp_q.push_back('{9'h0, 1'b0, 16'd0, 16'd0});
    bus(st(K_IDLE, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 9'h0, 1'b0, 16'd0, 16'd0));
    e = exp_q.pop_front();
    checks++;
    if ({err_vec, err_pulse, err_count, xfer_count} !== {e.vec, e.pulse, e.cnt, e.xfer})
      $display("FAIL reset_release: got vec=%03h pulse=%b cnt=%0d xfer=%0d, want vec=%03h pulse=%b cnt=%0d xfer=%0d",
               err_vec, err_pulse, err_count, xfer_count, e.vec, e.pulse, e.cnt, e.xfer);
    else passes++;
  endtask

  task automatic test_legal();
    step_t s[$];
    exp_t  e;
    s.push_back(st(K_SETUP, 32'h10, 1'b1, 32'hA5, 1'b0, 1'b0, 9'h0, 1'b0, 16'd0, 16'd0));
    s.push_back(st(K_WAIT,  32'h10, 1'b1, 32'hA5, 1'b0, 1'b0, 9'h0, 1'b0, 16'd0, 16'd0));
    s.push_back(st(K_WAIT,  32'h10, 1'b1, 32'hA5, 1'b0, 1'b1, 9'h0, 1'b0, 16'd0, 16'd0));
    s.push_back(st(K_LAST,  32'h10, 1'b1, 32'hA5, 1'b0, 1'b1, 9'h0, 1'b0, 16'd0, 16'd1));
    s.push_back(st(K_IDLE,  32'h10, 1'b1, 32'hA5, 1'b0, 1'b0, 9'h0, 1'b0, 16'd0, 16'd0));
    s.push_back(st(K_SETUP, 32'h20, 1'b0, 32'h0,  1'b0, 1'b0, 9'h0, 1'b0, 16'd0, 16'd0));
    s.push_back(st(K_LAST,  32'h20, 1'b0, 32'h0,  1'b0, 1'b1, 9'h0, 1'b0, 16'd0, 16'd2));
    s.push_back(st(K_IDLE,  32'h20, 1'b0, 32'h0,  1'b0, 1'b1, 9'h0, 1'b0, 16'd0, 16'd2));
    foreach (s[i]) begin
      if (s[i].chk) exp_q.push_back('{s[i].vec, s[i].pulse, s[i].cnt, s[i].xfer});
      bus(s[i]);
      checks++;
      if (apb_state !== 2'(s[i].kind)) $display("FAIL legal_state[%0d]: got %0d, want %0d", i, apb_state, s[i].kind);
      else passes++;
      if (s[i].chk) begin
        e = exp_q.pop_front();
        checks++;
        if ({err_vec, err_pulse, err_count, xfer_count} !== {e.vec, e.pulse, e.cnt, e.xfer})
          $display("FAIL legal[%0d]: got vec=%03h pulse=%b cnt=%0d xfer=%0d, want vec=%03h pulse=%b cnt=%0d xfer=%0d",
                   i, err_vec, err_pulse, err_count, xfer_count, e.vec, e.pulse, e.cnt, e.xfer);
        else passes++;
      end
    end
  endtask

  task automatic test_idle_to_access();
    step_t s[$];
    exp_t  e;
    s.push_back(st(K_WAIT, 32'h20, 1'b0, 32'h0, 1'b0, 1'b1, 9'h001, 1'b1, 16'd1, 16'd2));
    s.push_back(st(K_LAST, 32'h20, 1'b0, 32'h0, 1'b0, 1'b1, 9'h001, 1'b0, 16'd1, 16'd3));
    s.push_back(st(K_IDLE, 32'h20, 1'b0, 32'h0, 1'b1, 1'b1, 9'h000, 1'b0, 16'd0, 16'd3));
    foreach (s[i]) begin
      if (s[i].chk) exp_q.push_back('{s[i].vec, s[i].pulse, s[i].cnt, s[i].xfer});
      bus(s[i]);
      if (s[i].chk) begin
        e = exp_q.pop_front();
        checks++;
        if ({err_vec, err_pulse, err_count, xfer_count} !== {e.vec, e.pulse, e.cnt, e.xfer})
          $display("FAIL idle_access[%0d]: got vec=%03h pulse=%b cnt=%0d xfer=%0d, want vec=%03h pulse=%b cnt=%0d xfer=%0d",
                   i, err_vec, err_pulse, err_count, xfer_count, e.vec, e.pulse, e.cnt, e.xfer);
        else passes++;
      end
    end
  endtask

  task automatic test_stability();
    step_t s[$];
    exp_t  e;
    s.push_back(st(K_SETUP, 32'h10, 1'b1, 32'h11, 1'b0, 1'b0, 9'h0,   1'b0, 16'd0, 16'd0));
    s.push_back(st(K_WAIT,  32'h10, 1'b1, 32'h11, 1'b0, 1'b0, 9'h0,   1'b0, 16'd0, 16'd0));
    s.push_back(st(K_WAIT,  32'h14, 1'b1, 32'h11, 1'b0, 1'b1, 9'h010, 1'b1, 16'd1, 16'd3));
    s.push_back(st(K_LAST,  32'h14, 1'b1, 32'h11, 1'b0, 1'b1, 9'h010, 1'b0, 16'd1, 16'd4));
    s.push_back(st(K_IDLE,  32'h14, 1'b1, 32'h11, 1'b0, 1'b0, 9'h0,   1'b0, 16'd0, 16'd0));
    s.push_back(st(K_SETUP, 32'h30, 1'b0, 32'h11, 1'b0, 1'b0, 9'h0,   1'b0, 16'd0, 16'd0));
    s.push_back(st(K_WAIT,  32'h30, 1'b0, 32'h22, 1'b0, 1'b1, 9'h010, 1'b0, 16'd1, 16'd4));
    s.push_back(st(K_LAST,  32'h30, 1'b0, 32'h33, 1'b0, 1'b1, 9'h010, 1'b0, 16'd1, 16'd5));
    s.push_back(st(K_IDLE,  32'h30, 1'b0, 32'h33, 1'b1, 1'b1, 9'h0,   1'b0, 16'd0, 16'd5));
    s.push_back(st(K_SETUP, 32'h40, 1'b1, 32'h55, 1'b0, 1'b0, 9'h0,   1'b0, 16'd0, 16'd0));
    s.push_back(st(K_WAIT,  32'h40, 1'b1, 32'h66, 1'b0, 1'b1, 9'h020, 1'b1, 16'd1, 16'd5));
    s.push_back(st(K_LAST,  32'h40, 1'b1, 32'h66, 1'b0, 1'b1, 9'h020, 1'b0, 16'd1, 16'd6));
    s.push_back(st(K_IDLE,  32'h40, 1'b1, 32'h66, 1'b1, 1'b1, 9'h0,   1'b0, 16'd0, 16'd6));
    foreach (s[i]) begin
      if (s[i].chk) exp_q.push_back('{s[i].vec, s[i].pulse, s[i].cnt, s[i].xfer});
      bus(s[i]);
      if (s[i].chk) begin
        e = exp_q.pop_front();
        checks++;
        if ({err_vec, err_pulse, err_count, xfer_count} !== {e.vec, e.pulse, e.cnt, e.xfer})
          $display("FAIL stability[%0d]: got vec=%03h pulse=%b cnt=%0d xfer=%0d, want vec=%03h pulse=%b cnt=%0d xfer=%0d",
                   i, err_vec, err_pulse, err_count, xfer_count, e.vec, e.pulse, e.cnt, e.xfer);
        else passes++;
      end
    end
  endtask

  task automatic test_psel_drop();
    step_t s[$];
    exp_t  e;
    s.push_back(st(K_SETUP, 32'h50, 1'b0, 32'h0, 1'b0, 1'b0, 9'h0,   1'b0, 16'd0, 16'd0));
    s.push_back(st(K_WAIT,  32'h50, 1'b0, 32'h0, 1'b0, 1'b0, 9'h0,   1'b0, 16'd0, 16'd0));
    s.push_back(st(K_IDLE,  32'h50, 1'b0, 32'h0, 1'b0, 1'b1, 9'h084, 1'b1, 16'd1, 16'd6));
    s.push_back(st(K_IDLE,  32'h50, 1'b0, 32'h0, 1'b0, 1'b1, 9'h084, 1'b0, 16'd1, 16'd6));
    // Clear collides with a new IDLE->ACCESS failure: only the new bit survives, count loads 1.
    s.push_back(st(K_WAIT,  32'h50, 1'b0, 32'h0, 1'b1, 1'b1, 9'h001, 1'b1, 16'd1, 16'd6));
    s.push_back(st(K_LAST,  32'h50, 1'b0, 32'h0, 1'b0, 1'b1, 9'h001, 1'b0, 16'd1, 16'd7));
    s.push_back(st(K_IDLE,  32'h50, 1'b0, 32'h0, 1'b1, 1'b1, 9'h0,   1'b0, 16'd0, 16'd7));
    foreach (s[i]) begin
      if (s[i].chk) exp_q.push_back('{s[i].vec, s[i].pulse, s[i].cnt, s[i].xfer});
      bus(s[i]);
      if (s[i].chk) begin
        e = exp_q.pop_front();
        checks++;
        if ({err_vec, err_pulse, err_count, xfer_count} !== {e.vec, e.pulse, e.cnt, e.xfer})
          $display("FAIL psel_drop[%0d]: got vec=%03h pulse=%b cnt=%0d xfer=%0d, want vec=%03h pulse=%b cnt=%0d xfer=%0d",
                   i, err_vec, err_pulse, err_count, xfer_count, e.vec, e.pulse, e.cnt, e.xfer);
        else passes++;
      end
    end
  endtask

  task automatic test_back_to_back();
    step_t s[$];
    exp_t  e;
    s.push_back(st(K_SETUP, 32'h60, 1'b1, 32'h1, 1'b0, 1'b0, 9'h0,   1'b0, 16'd0, 16'd0));
    s.push_back(st(K_LAST,  32'h60, 1'b1, 32'h1, 1'b0, 1'b0, 9'h0,   1'b0, 16'd0, 16'd0));
    s.push_back(st(K_SETUP, 32'h64, 1'b1, 32'h2, 1'b0, 1'b0, 9'h0,   1'b0, 16'd0, 16'd0));
    s.push_back(st(K_LAST,  32'h64, 1'b1, 32'h2, 1'b0, 1'b1, 9'h0,   1'b0, 16'd0, 16'd9));
    s.push_back(st(K_LAST,  32'h64, 1'b1, 32'h2, 1'b0, 1'b1, 9'h008, 1'b1, 16'd1, 16'd10));
    s.push_back(st(K_SETUP, 32'h64, 1'b1, 32'h2, 1'b0, 1'b0, 9'h0,   1'b0, 16'd0, 16'd0));
    s.push_back(st(K_WAIT,  32'h64, 1'b1, 32'h2, 1'b0, 1'b0, 9'h0,   1'b0, 16'd0, 16'd0));
    s.push_back(st(K_SETUP, 32'h64, 1'b1, 32'h2, 1'b0, 1'b1, 9'h04C, 1'b1, 16'd2, 16'd10));
    s.push_back(st(K_WAIT,  32'h64, 1'b1, 32'h2, 1'b0, 1'b0, 9'h0,   1'b0, 16'd0, 16'd0));
    s.push_back(st(K_LAST,  32'h64, 1'b1, 32'h2, 1'b0, 1'b0, 9'h0,   1'b0, 16'd0, 16'd0));
    s.push_back(st(K_IDLE,  32'h64, 1'b1, 32'h2, 1'b1, 1'b1, 9'h0,   1'b0, 16'd0, 16'd11));
    s.push_back(st(K_SETUP, 32'h70, 1'b0, 32'h2, 1'b0, 1'b0, 9'h0,   1'b0, 16'd0, 16'd0));
    s.push_back(st(K_IDLE,  32'h70, 1'b0, 32'h2, 1'b0, 1'b1, 9'h082, 1'b1, 16'd1, 16'd11));
    s.push_back(st(K_IDLE,  32'h70, 1'b0, 32'h2, 1'b1, 1'b1, 9'h0,   1'b0, 16'd0, 16'd11));
    foreach (s[i]) begin
      if (s[i].chk) exp_q.push_back('{s[i].vec, s[i].pulse, s[i].cnt, s[i].xfer});
      bus(s[i]);
      if (s[i].chk) begin
        e = exp_q.pop_front();
        checks++;
        if ({err_vec, err_pulse, err_count, xfer_count} !== {e.vec, e.pulse, e.cnt, e.xfer})
          $display("FAIL back_to_back[%0d]: got vec=%03h pulse=%b cnt=%0d xfer=%0d, want vec=%03h pulse=%b cnt=%0d xfer=%0d",
                   i, err_vec, err_pulse, err_count, xfer_count, e.vec, e.pulse, e.cnt, e.xfer);
        else passes++;
      end
    end
  endtask

  task automatic test_timeout();
    step_t s[$];
    exp_t  e;
    s.push_back(st(K_SETUP, 32'h80, 1'b0, 32'h0, 1'b0, 1'b0, 9'h0, 1'b0, 16'd0, 16'd0));
    for (int i = 0; i < 5; i++)
      s.push_back(st(K_WAIT, 32'h80, 1'b0, 32'h0, 1'b0, 1'b1,
                     (TMO_ON && i >= TMO - 1) ? 9'h100 : 9'h000,
                     TMO_ON && (i == TMO - 1),
                     (TMO_ON && i >= TMO - 1) ? 16'd1 : 16'd0, 16'd11));
    s.push_back(st(K_LAST, 32'h80, 1'b0, 32'h0, 1'b0, 1'b1, TMO_ON ? 9'h100 : 9'h000, 1'b0,
                   TMO_ON ? 16'd1 : 16'd0, 16'd12));
    s.push_back(st(K_IDLE, 32'h80, 1'b0, 32'h0, 1'b1, 1'b1, 9'h0, 1'b0, 16'd0, 16'd12));
    foreach (s[i]) begin
      if (s[i].chk) exp_q.push_back('{s[i].vec, s[i].pulse, s[i].cnt, s[i].xfer});
      bus(s[i]);
      if (s[i].chk) begin
        e = exp_q.pop_front();
        checks++;
        if ({err_vec, err_pulse, err_count, xfer_count} !== {e.vec, e.pulse, e.cnt, e.xfer})
          $display("FAIL timeout[%0d]: got vec=%03h pulse=%b cnt=%0d xfer=%0d, want vec=%03h pulse=%b cnt=%0d xfer=%0d",
                   i, err_vec, err_pulse, err_count, xfer_count, e.vec, e.pulse, e.cnt, e.xfer);
        else passes++;
      end
    end
  endtask

  task automatic test_reset_mid();
    step_t s[$];
    exp_t  e;
    bus(st(K_SETUP, 32'h90, 1'b0, 32'h0, 1'b0, 1'b0, 9'h0, 1'b0, 16'd0, 16'd0));
    bus(st(K_WAIT,  32'h90, 1'b0, 32'h0, 1'b0, 1'b0, 9'h0, 1'b0, 16'd0, 16'd0));
    preset = 1'b1;
    bus(st(K_WAIT,  32'h90, 1'b0, 32'h0, 1'b0, 1'b0, 9'h0, 1'b0, 16'd0, 16'd0));
    checks++;
    if ({err_vec, err_pulse, err_count, xfer_count} !== 42'd0)
      $display("FAIL reset_mid_clear: got vec=%03h pulse=%b cnt=%0d xfer=%0d, want all 0",
               err_vec, err_pulse, err_count, xfer_count);
    else passes++;
    preset = 1'b0;
    s.push_back(st(K_IDLE, 32'h90, 1'b0, 32'h0, 1'b0, 1'b1, 9'h0, 1'b0, 16'd0, 16'd0));
    s.push_back(st(K_IDLE, 32'h90, 1'b0, 32'h0, 1'b0, 1'b1, 9'h0, 1'b0, 16'd0, 16'd0));
    s.push_back(st(K_IDLE, 32'h90, 1'b0, 32'h0, 1'b1, 1'b0, 9'h0, 1'b0, 16'd0, 16'd0));
    s.push_back(st(K_IDLE, 32'h90, 1'b0, 32'h0, 1'b0, 1'b0, 9'h0, 1'b0, 16'd0, 16'd0));
    foreach (s[i]) begin
      if (s[i].chk) exp_q.push_back('{s[i].vec, s[i].pulse, s[i].cnt, s[i].xfer});
      bus(s[i]);
      if (s[i].chk) begin
        e = exp_q.pop_front();
        checks++;
        if ({err_vec, err_pulse, err_count, xfer_count} !== {e.vec, e.pulse, e.cnt, e.xfer})
          $display("FAIL reset_mid[%0d]: got vec=%03h pulse=%b cnt=%0d xfer=%0d, want vec=%03h pulse=%b cnt=%0d xfer=%0d",
                   i, err_vec, err_pulse, err_count, xfer_count, e.vec, e.pulse, e.cnt, e.xfer);
        else passes++;
      end
    end
    // Reset released while the bus sits in ACCESS: the first sample must not be judged.
    preset = 1'b1;
    bus(st(K_WAIT, 32'hA0, 1'b0, 32'h0, 1'b0, 1'b0, 9'h0, 1'b0, 16'd0, 16'd0));
    preset = 1'b0;
    s.delete();
    s.push_back(st(K_WAIT, 32'hA0, 1'b0, 32'h0, 1'b0, 1'b1, 9'h0, 1'b0, 16'd0, 16'd0));
    s.push_back(st(K_LAST, 32'hA0, 1'b0, 32'h0, 1'b0, 1'b1, 9'h0, 1'b0, 16'd0, 16'd1));
    s.push_back(st(K_IDLE, 32'hA0, 1'b0, 32'h0, 1'b0, 1'b1, 9'h0, 1'b0, 16'd0, 16'd1));
    foreach (s[i]) begin
      if (s[i].chk) exp_q.push_back('{s[i].vec, s[i].pulse, s[i].cnt, s[i].xfer});
      bus(s[i]);
      if (s[i].chk) begin
        e = exp_q.pop_front();
        checks++;
        if ({err_vec, err_pulse, err_count, xfer_count} !== {e.vec, e.pulse, e.cnt, e.xfer})
          $display("FAIL reset_in_access[%0d]: got vec=%03h pulse=%b cnt=%0d xfer=%0d, want vec=%03h pulse=%b cnt=%0d xfer=%0d",
                   i, err_vec, err_pulse, err_count, xfer_count, e.vec, e.pulse, e.cnt, e.xfer);
        else passes++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_legal();
    test_idle_to_access();
    test_stability();
    test_psel_drop();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
